// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : shared types and sizing helpers for the 3x3 convolution sequencer
// Revision : 1.0
// ============================================================================
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int KERNEL = 3;

  function automatic int tap_count(input int in_ch);
    return KERNEL * KERNEL * in_ch;
  endfunction

  function automatic int addr_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_tap_gen.sv
`default_nettype none
// ============================================================================
// conv3x3_tap_gen : ic/ky/kx tap walker with padding detection and addressing
// Revision        : 1.0
// ============================================================================
module conv3x3_tap_gen
  import conv_pkg::*;
#(
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int IN_AW        = addr_w(IN_CHANNELS * IN_HEIGHT * IN_WIDTH),
  parameter int W_AW         = addr_w(tap_count(OUT_CHANNELS * IN_CHANNELS)),
  parameter int OCW          = addr_w(OUT_CHANNELS),
  parameter int OYW          = addr_w(IN_HEIGHT),
  parameter int OXW          = addr_w(IN_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic [OCW-1:0]   oc,
  input  logic [OYW-1:0]   oy,
  input  logic [OXW-1:0]   ox,
  output logic             in_rd_en,
  output logic [IN_AW-1:0] in_addr,
  output logic             w_rd_en,
  output logic [W_AW-1:0]  w_addr,
  output logic             pad,
  output logic             last_tap
);

  localparam int ICW = addr_w(IN_CHANNELS);
  localparam logic [1:0] K_LAST = 2'(KERNEL - 1);

  logic [ICW-1:0] ic;
  logic [1:0]     ky;
  logic [1:0]     kx;
  logic           last_ic;
  logic           inb;
  int             iy;
  int             ix;

  assign last_ic = (int'(ic) == IN_CHANNELS - 1);

  // Counters wrap to zero after the last tap, so every FETCH run starts clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic <= '0;
      ky <= '0;
      kx <= '0;
    end else if (active) begin
      if (kx == K_LAST) begin
        kx <= '0;
        if (ky == K_LAST) begin
          ky <= '0;
          ic <= last_ic ? '0 : ic + ICW'(1);
        end else begin
          ky <= ky + 2'd1;
        end
      end else begin
        kx <= kx + 2'd1;
      end
    end
  end

  always_comb begin
    iy       = int'(oy) + int'(ky) - 1;
    ix       = int'(ox) + int'(kx) - 1;
    inb      = (iy >= 0) && (iy < IN_HEIGHT) && (ix >= 0) && (ix < IN_WIDTH);
    pad      = !inb;
    last_tap = last_ic && (ky == K_LAST) && (kx == K_LAST);
    in_rd_en = active && inb;
    w_rd_en  = active;
    in_addr  = '0;
    w_addr   = '0;
    if (in_rd_en)
      in_addr = IN_AW'(int'(ic) * IN_HEIGHT * IN_WIDTH + iy * IN_WIDTH + ix);
    if (active)
      w_addr = W_AW'((int'(oc) * IN_CHANNELS + int'(ic)) * KERNEL * KERNEL
                     + int'(ky) * KERNEL + int'(kx));
  end

endmodule
`default_nettype wire

// File: rtl/conv3x3_sched.sv
`default_nettype none
// ============================================================================
// conv3x3_sched : streaming 3x3 conv sequencer (stride 1, pad 1) with bias MAC
// Option        : CONV3X3_SCHED_RELU_EN clamps negative outputs to zero
// Revision      : 1.0
// ============================================================================
module conv3x3_sched
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  localparam int IN_AW  = addr_w(IN_CHANNELS * IN_HEIGHT * IN_WIDTH),
  localparam int W_AW   = addr_w(tap_count(OUT_CHANNELS * IN_CHANNELS)),
  localparam int OUT_AW = addr_w(OUT_CHANNELS * IN_HEIGHT * IN_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           in_rd_en,
  output logic [IN_AW-1:0]               in_addr,
  input  logic [DATA_WIDTH-1:0]          in_rdata,
  output logic                           w_rd_en,
  output logic [W_AW-1:0]                w_addr,
  input  logic [DATA_WIDTH-1:0]          w_rdata,
  input  logic [OUT_CHANNELS*DATA_WIDTH-1:0] bias_flat,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [OUT_AW-1:0]              out_addr
);

  localparam int OCW = addr_w(OUT_CHANNELS);
  localparam int OYW = addr_w(IN_HEIGHT);
  localparam int OXW = addr_w(IN_WIDTH);

  state_t                state, state_nx;
  logic [OCW-1:0]        oc, oc_nx;
  logic [OYW-1:0]        oy, oy_nx;
  logic [OXW-1:0]        ox, ox_nx;
  logic                  last_out;
  logic                  accept;
  logic                  last_tap;
  logic                  pad;
  logic                  mac_v;
  logic                  pad_d;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] prod;

  conv3x3_tap_gen #(
    .IN_CHANNELS (IN_CHANNELS),
    .OUT_CHANNELS(OUT_CHANNELS),
    .IN_HEIGHT   (IN_HEIGHT),
    .IN_WIDTH    (IN_WIDTH),
    .IN_AW       (IN_AW),
    .W_AW        (W_AW),
    .OCW         (OCW),
    .OYW         (OYW),
    .OXW         (OXW)
  ) u_tap_gen (
    .clk     (clk),
    .rst     (rst),
    .active  (state == ST_FETCH),
    .oc      (oc),
    .oy      (oy),
    .ox      (ox),
    .in_rd_en(in_rd_en),
    .in_addr (in_addr),
    .w_rd_en (w_rd_en),
    .w_addr  (w_addr),
    .pad     (pad),
    .last_tap(last_tap)
  );

  assign accept   = (state == ST_EMIT) && out_ready;
  assign last_out = (int'(ox) == IN_WIDTH - 1) && (int'(oy) == IN_HEIGHT - 1)
                 && (int'(oc) == OUT_CHANNELS - 1);
  assign prod     = in_rdata * w_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_FETCH;
      ST_FETCH: if (last_tap) state_nx = ST_DRAIN;
      ST_DRAIN: state_nx = ST_EMIT;
      ST_EMIT:  if (out_ready) state_nx = last_out ? ST_DONE : ST_FETCH;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Raster advance: ox fastest, then oy, then oc.
  always_comb begin
    ox_nx = ox;
    oy_nx = oy;
    oc_nx = oc;
    if (int'(ox) == IN_WIDTH - 1) begin
      ox_nx = '0;
      if (int'(oy) == IN_HEIGHT - 1) begin
        oy_nx = '0;
        oc_nx = (int'(oc) == OUT_CHANNELS - 1) ? '0 : oc + OCW'(1);
      end else begin
        oy_nx = oy + OYW'(1);
      end
    end else begin
      ox_nx = ox + OXW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oc <= '0;
      oy <= '0;
      ox <= '0;
    end else if ((state == ST_IDLE) && start) begin
      oc <= '0;
      oy <= '0;
      ox <= '0;
    end else if (accept) begin
      oc <= oc_nx;
      oy <= oy_nx;
      ox <= ox_nx;
    end
  end

  // mac_v/pad_d follow each tap by one cycle to line up with the memory data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      mac_v <= 1'b0;
      pad_d <= 1'b0;
    end else begin
      mac_v <= (state == ST_FETCH);
      pad_d <= pad;
      if ((state == ST_IDLE) && start)
        acc <= bias_flat[0 +: DATA_WIDTH];
      else if (accept && !last_out)
        acc <= bias_flat[int'(oc_nx) * DATA_WIDTH +: DATA_WIDTH];
      else if (mac_v)
        acc <= acc + (pad_d ? '0 : prod);
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign out_valid = (state == ST_EMIT);

  always_comb begin
    out_data = '0;
    out_addr = '0;
    if (out_valid) begin
`ifdef CONV3X3_SCHED_RELU_EN
      out_data = acc[DATA_WIDTH-1] ? '0 : acc;
`else
      out_data = acc;
`endif
      out_addr = OUT_AW'(int'(oc) * IN_HEIGHT * IN_WIDTH + int'(oy) * IN_WIDTH + int'(ox));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_sched.sv
`default_nettype none
// ============================================================================
// tb_conv3x3_sched : scoreboard bench for conv3x3_sched (4x4, IC=OC=1)
// Revision         : 1.0
// ============================================================================
module tb_conv3x3_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done;
  logic        in_rd_en, w_rd_en;
  logic [3:0]  in_addr, w_addr, out_addr;
  logic [31:0] in_rdata, w_rdata, out_data;
  logic [31:0] bias_flat;
  logic        out_valid, out_ready;

  logic [31:0] in_mem [16];
  logic [31:0] w_mem  [9];
  logic [31:0] exp_data [$];
  logic [3:0]  exp_addr [$];
  int          spec_tab [16];

  int errors = 0, checks = 0;
  int cyc = 0, start_cyc = 0, done_lat = 0;
  int out_count = 0, done_count = 0, reads0 = 0;
  bit base_test = 0, wrap_test = 0;
  bit held_v = 0;
  logic [31:0] held_d;
  logic [3:0]  held_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  conv3x3_sched #(
    .DATA_WIDTH(32), .IN_CHANNELS(1), .OUT_CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_rd_en(in_rd_en), .in_addr(in_addr), .in_rdata(in_rdata),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .bias_flat(bias_flat), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr)
  );

  // One-cycle-latency memories; unread cycles return junk so pads must be masked.
  always @(posedge clk) begin
    in_rdata <= in_rd_en ? in_mem[in_addr] : 32'hDEAD_BEEF;
    w_rdata  <= w_rd_en  ? w_mem[w_addr]   : 32'hBAD0_C0DE;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_expected();
    logic [31:0] a;
    int iy, ix;
    exp_data.delete();
    exp_addr.delete();
    for (int oy = 0; oy < 4; oy++) begin
      for (int ox = 0; ox < 4; ox++) begin
        a = bias_flat;
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            iy = oy + ky - 1;
            ix = ox + kx - 1;
            if (iy >= 0 && iy < 4 && ix >= 0 && ix < 4)
              a = a + in_mem[iy*4+ix] * w_mem[ky*3+kx];
          end
        end
`ifdef CONV3X3_SCHED_RELU_EN
        if (a[31]) a = 32'd0;
`endif
        exp_data.push_back(a);
        exp_addr.push_back(4'(oy*4+ox));
      end
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) in_mem[i] = 32'(i);
    for (int i = 0; i < 9; i++)  w_mem[i]  = 32'd1;
    bias_flat = 32'd0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (held_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_d);
        check("hold_addr", out_addr, held_a);
        check("stall_reads", {in_rd_en, w_rd_en}, 0);
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_a = out_addr;
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          check("sb_extra_output", out_addr, 4'hF);
          check("sb_empty", 1, 0);
        end else begin
          check("out_addr", out_addr, exp_addr.pop_front());
          check("out_data", out_data, exp_data.pop_front());
        end
        if (base_test && (out_count <= 5 || out_count == 15))
          check("ref_val", out_data, spec_tab[out_count]);
        if (wrap_test && out_count == 0)
`ifdef CONV3X3_SCHED_RELU_EN
          check("wrap_relu", out_data, 32'h0);
`else
          check("wrap_raw", out_data, 32'h8000_0000);
`endif
        out_count++;
      end
      if (in_rd_en && out_count == 0) begin
        reads0++;
        check("pad_tap", (w_addr / 3 == 0) || (w_addr % 3 == 0), 0);
      end
      if (done) begin
        done_count++;
        // index of the edge that samples done, relative to the start edge
        done_lat = cyc + 1 - start_cyc;
      end
    end else begin
      held_v = 0;
    end
  end

  task automatic run_conv(input int exp_lat, input bit stall5, input bit extra_start);
    load_expected();
    out_count  = 0;
    done_count = 0;
    reads0     = 0;
    tick();
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
    if (extra_start) begin
      repeat (20) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (stall5) begin
      for (int i = 0; i < 500 && !(out_count == 5 && out_valid); i++) tick();
      check("stall_reach", out_count == 5 && out_valid, 1);
      out_ready = 1'b0;
      repeat (5) tick();
      out_ready = 1'b1;
    end
    for (int i = 0; i < 3000 && done_count == 0; i++) tick();
    check("done_seen", done_count != 0, 1);
    repeat (5) tick();
    check("done_latency", done_lat, exp_lat);
    check("done_pulses", done_count, 1);
    check("out_count", out_count, 16);
    check("sb_left", exp_data.size(), 0);
    check("pad_reads", reads0, 4);
  endtask

  task automatic check_reset_values();
    check("rv_busy", busy, 0);
    check("rv_done", done, 0);
    check("rv_in_rd_en", in_rd_en, 0);
    check("rv_w_rd_en", w_rd_en, 0);
    check("rv_out_valid", out_valid, 0);
    check("rv_in_addr", in_addr, 0);
    check("rv_w_addr", w_addr, 0);
    check("rv_out_data", out_data, 0);
    check("rv_out_addr", out_addr, 0);
  endtask

  initial begin
    spec_tab = '{10, 18, 24, 18, 27, 45, 0, 0, 0, 0, 0, 0, 0, 0, 0, 50};
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    load_ramp();
    repeat (3) tick();
    check_reset_values();
    rst = 1'b1;
    tick();

    base_test = 1;
    run_conv(177, 0, 1);
    run_conv(182, 1, 0);
    base_test = 0;

    for (int i = 0; i < 16; i++) in_mem[i] = 32'd0;
    for (int i = 0; i < 9; i++)  w_mem[i]  = 32'd0;
    in_mem[0] = 32'd1;
    w_mem[4]  = 32'd1;
    bias_flat = 32'h7FFF_FFFF;
    wrap_test = 1;
    run_conv(177, 0, 0);
    wrap_test = 0;

    load_ramp();
    base_test = 1;
    load_expected();
    out_count = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 500 && !(out_count == 7 && w_rd_en); i++) tick();
    check("rst_reach", out_count == 7 && w_rd_en, 1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_values();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    run_conv(177, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
